// File: rtl/bus_cycle_initiator.sv
// Bus-master side of the multiplexed ALE/IOM/RD/WR protocol: runs one T1-T2-T3-(Tw)-T4
// cycle per accepted command. Wait states are bounded by MAX_WAIT.
module bus_cycle_initiator #(
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              req_we,
  input  logic              req_iom,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [DATA_W-1:0] rdata,
  input  logic              ready,
  input  logic [DATA_W-1:0] ad_in,
  output logic [ADDR_W-1:0] ad_out,
  output logic              ad_oe,
  output logic              ale,
  output logic              iom,
  output logic              rd_n,
  output logic              wr_n,
  output logic [2:0]        dbg_state
);

  localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    T3   = 3'd3,
    TW   = 3'd4,
    T4   = 3'd5
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              we_q;
  logic              iom_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic              to_flag;
  logic              wait_expired;

  assign wait_expired = (wait_cnt == WAIT_MAX);
  assign dbg_state    = state;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = T1;
      T1:      state_nxt = T2;
      T2:      state_nxt = T3;
      T3, TW:  begin
        if (ready || wait_expired) state_nxt = T4;
        else                       state_nxt = TW;
      end
      T4:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Command latch, wait counting and read-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q     <= 1'b0;
      iom_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wait_cnt <= '0;
      to_flag  <= 1'b0;
      rdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            we_q    <= req_we;
            iom_q   <= req_iom;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
          end
        end
        T3, TW: begin
          if (ready) begin
            if (!we_q) rdata <= ad_in;
          end else if (wait_expired) begin
            // A timed-out read returns all ones so software can spot it.
            to_flag <= 1'b1;
            if (!we_q) rdata <= '1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        T4: begin
          wait_cnt <= '0;
          to_flag  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ale     = 1'b0;
    ad_oe   = 1'b0;
    ad_out  = '0;
    rd_n    = 1'b1;
    wr_n    = 1'b1;
    done    = 1'b0;
    timeout = 1'b0;
    busy    = (state != IDLE);
    iom     = (state != IDLE) && iom_q;
    case (state)
      T1: begin
        ale    = 1'b1;
        ad_oe  = 1'b1;
        ad_out = addr_q;
      end
      T2, T3, TW: begin
        if (we_q) begin
          wr_n                 = 1'b0;
          ad_oe                = 1'b1;
          ad_out[DATA_W-1:0]   = wdata_q;
        end else begin
          rd_n = 1'b0;
        end
      end
      T4: begin
        done    = 1'b1;
        timeout = to_flag;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_cycle_initiator.sv
// Bench for bus_cycle_initiator: cycle-by-cycle bus checks plus a completion scoreboard.
// A second instance with MAX_WAIT=0 covers the no-wait-allowed boundary.
module tb_bus_cycle_initiator;

  localparam int MW = 15;
  localparam logic [2:0] S_IDLE = 3'd0, S_T1 = 3'd1, S_T2 = 3'd2,
                         S_T3 = 3'd3, S_TW = 3'd4, S_T4 = 3'd5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0, req_we = 1'b0, req_iom = 1'b0;
  logic [19:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        busy, done, timeout;
  logic [7:0]  rdata;
  logic        ready = 1'b0;
  logic [7:0]  ad_in = '0;
  logic [19:0] ad_out;
  logic        ad_oe, ale, iom, rd_n, wr_n;
  logic [2:0]  dbg_state;

  logic        z_req = 1'b0, z_ready = 1'b0;
  logic [7:0]  z_ad_in = '0;
  logic        z_busy, z_done, z_timeout, z_ad_oe, z_ale, z_iom, z_rd_n, z_wr_n;
  logic [7:0]  z_rdata;
  logic [19:0] z_ad_out;
  logic [2:0]  z_dbg_state;

  int          n_vec = 0;
  int          n_err = 0;
  logic [8:0]  exp_q[$];      // {timeout, rdata}
  logic [7:0]  exp_rdata = '0;

  always #5 clk = ~clk;

  bus_cycle_initiator #(.ADDR_W(20), .DATA_W(8), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_iom(req_iom),
    .req_addr(req_addr), .req_wdata(req_wdata), .busy(busy), .done(done),
    .timeout(timeout), .rdata(rdata), .ready(ready), .ad_in(ad_in),
    .ad_out(ad_out), .ad_oe(ad_oe), .ale(ale), .iom(iom), .rd_n(rd_n),
    .wr_n(wr_n), .dbg_state(dbg_state)
  );

  bus_cycle_initiator #(.ADDR_W(20), .DATA_W(8), .MAX_WAIT(0)) dut_zero (
    .clk(clk), .rst(rst), .req(z_req), .req_we(1'b0), .req_iom(1'b0),
    .req_addr(20'h00ABC), .req_wdata(8'h00), .busy(z_busy), .done(z_done),
    .timeout(z_timeout), .rdata(z_rdata), .ready(z_ready), .ad_in(z_ad_in),
    .ad_out(z_ad_out), .ad_oe(z_ad_oe), .ale(z_ale), .iom(z_iom), .rd_n(z_rd_n),
    .wr_n(z_wr_n), .dbg_state(z_dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        check("sb_timeout", 32'(timeout), 32'(e[8]));
        check("sb_rdata", 32'(rdata), 32'(e[7:0]));
      end
    end
  end

  // nw = number of ready=0 samples before ready=1; nw > MW forces a timeout.
  task automatic do_cycle(input logic we, input logic io, input logic [19:0] addr,
                          input logic [7:0] wd, input int nw, input logic [7:0] rv);
    int   nt;
    logic to;
    nt = (nw > MW) ? MW : nw;
    to = (nw > MW);
    if (!we) exp_rdata = to ? 8'hFF : rv;
    exp_q.push_back({to, exp_rdata});

    req = 1'b1; req_we = we; req_iom = io; req_addr = addr; req_wdata = wd;
    ad_in = rv; ready = 1'b0;
    step();
    req = 1'b0;
    check("t1_state", 32'(dbg_state), 32'(S_T1));
    check("t1_ale", 32'(ale), 32'd1);
    check("t1_ad_out", 32'(ad_out), 32'(addr));
    check("t1_ad_oe", 32'(ad_oe), 32'd1);
    check("t1_iom", 32'(iom), 32'(io));
    step();
    check("t2_state", 32'(dbg_state), 32'(S_T2));
    check("t2_ale", 32'(ale), 32'd0);
    check("t2_rd_n", 32'(rd_n), 32'(we));
    check("t2_wr_n", 32'(wr_n), 32'(!we));
    check("t2_ad_oe", 32'(ad_oe), 32'(we));
    if (we) check("t2_ad_out", 32'(ad_out), 32'(wd));
    for (int s = 0; s <= nt; s++) begin
      step();
      ready = (s >= nw);
      check("tw_state", 32'(dbg_state), (s == 0) ? 32'(S_T3) : 32'(S_TW));
      check("tw_strobe", 32'({rd_n, wr_n}), we ? 32'b10 : 32'b01);
      check("tw_ad_oe", 32'(ad_oe), 32'(we));
      if (we) check("tw_ad_out", 32'(ad_out), 32'(wd));
      check("tw_iom", 32'(iom), 32'(io));
      check("tw_done", 32'(done), 32'd0);
    end
    step();
    ready = 1'b0;
    check("t4_state", 32'(dbg_state), 32'(S_T4));
    check("t4_done", 32'(done), 32'd1);
    check("t4_timeout", 32'(timeout), 32'(to));
    check("t4_bus", 32'({rd_n, wr_n, ad_oe, ale}), 32'b1100);
    check("t4_iom", 32'(iom), 32'(io));
    step();
    check("idle_state", 32'(dbg_state), 32'(S_IDLE));
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_iom", 32'(iom), 32'd0);
    check("idle_done", 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    step(); step();
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    check("rst_bus", 32'({ale, rd_n, wr_n, ad_oe, iom}), 32'b01100);
    check("rst_ad_out", 32'(ad_out), 32'd0);
    check("rst_flags", 32'({busy, done, timeout}), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    rst = 1'b0;
    step();

    do_cycle(1'b0, 1'b0, 20'h12345, 8'h00, 0, 8'hA5);   // zero-wait memory read
    do_cycle(1'b1, 1'b1, 20'h0F00D, 8'h3C, 2, 8'h11);   // write, two waits
    do_cycle(1'b0, 1'b0, 20'h00100, 8'h00, 40, 8'h22);  // read timeout
    do_cycle(1'b0, 1'b1, 20'h00200, 8'h00, 15, 8'h77);  // ready in last Tw
    do_cycle(1'b1, 1'b0, 20'h00300, 8'h99, 40, 8'h33);  // write timeout, rdata kept

    for (int i = 0; i < 6; i++)
      do_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               20'($urandom_range(0, 20'hFFFFF)), 8'($urandom_range(0, 255)),
               $urandom_range(0, MW + 2), 8'($urandom_range(0, 255)));

    // Reset during a write wait state aborts without a done pulse.
    req = 1'b1; req_we = 1'b1; req_iom = 1'b1; req_wdata = 8'h5E; ready = 1'b0;
    step(); req = 1'b0;
    step(); step(); step();
    check("abort_in_tw", 32'(dbg_state), 32'(S_TW));
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_rdata = 8'h00;
    check("abort_bus", 32'({wr_n, ad_oe, busy, done}), 32'b1000);
    check("abort_rdata", 32'(rdata), 32'd0);
    do_cycle(1'b0, 1'b0, 20'h0BEEF, 8'h00, 0, 8'hC3);

    // req held high: T1 at cycles 1 and 6; pulses while busy are ignored.
    exp_q.push_back({1'b0, 8'h5A});
    exp_q.push_back({1'b0, 8'h5A});
    exp_rdata = 8'h5A;
    req = 1'b1; req_we = 1'b0; req_iom = 1'b0; ready = 1'b1; ad_in = 8'h5A;
    step(); check("hold_c1", 32'(dbg_state), 32'(S_T1));
    step(); step(); step();
    check("hold_c4", 32'(dbg_state), 32'(S_T4));
    step(); check("hold_c5", 32'(dbg_state), 32'(S_IDLE));
    step(); check("hold_c6", 32'(dbg_state), 32'(S_T1));
    req = 1'b0;
    step(); req = 1'b1;
    step(); req = 1'b0;
    step(); req = 1'b1;
    check("hold_c9", 32'(dbg_state), 32'(S_T4));
    step(); req = 1'b0;
    check("hold_c10", 32'(dbg_state), 32'(S_IDLE));
    step(); check("hold_c11", 32'(dbg_state), 32'(S_IDLE));
    ready = 1'b0;

    // MAX_WAIT=0: ready low in T3 times out in cycle 4.
    z_req = 1'b1; z_ready = 1'b0; z_ad_in = 8'h42;
    step(); z_req = 1'b0;
    step(); step();
    check("z_t3", 32'(z_dbg_state), 32'(S_T3));
    step();
    check("z_to_done", 32'({z_done, z_timeout}), 32'b11);
    check("z_to_rdata", 32'(z_rdata), 32'hFF);
    step();
    z_req = 1'b1; z_ready = 1'b1;
    step(); z_req = 1'b0;
    step(); step(); step();
    check("z_ok_done", 32'({z_done, z_timeout}), 32'b10);
    check("z_ok_rdata", 32'(z_rdata), 32'h42);
    step();

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
